// File: rtl/muldiv_pkg.sv
// Shared constants, state encoding and fast-path helper for the RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN    = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Divide-by-zero and signed overflow bypass the iterative datapath entirely.
  function automatic logic fast_path(input logic [2:0] f, input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
    logic div_zero;
    logic div_ovf;
    div_zero = (b == '0);
    div_ovf  = !f[0] && (a == INT_MIN) && (b == DIV_ZERO_Q);
    return f[2] && (div_zero || div_ovf);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Bundle between the decode/register-file side (master) and the multiply/divide unit (slave).
interface muldiv_if;
  import muldiv_pkg::*;

  // start is a request taken only while busy is low; there is no ready back-pressure,
  // so a start seen while busy is dropped. result_valid is a single-cycle write strobe
  // with result/rd_out valid alongside it; the consumer cannot stall it.
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_in;
  logic            busy;
  logic            result_valid;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;
  state_e          dbg_state;

  modport master (
    output start, flush, funct3, op_a, op_b, rd_in,
    input  busy, result_valid, result, rd_out, dbg_state
  );

  modport slave (
    input  start, flush, funct3, op_a, op_b, rd_in,
    output busy, result_valid, result, rd_out, dbg_state
  );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring divide on
// operand magnitudes, followed by a one-cycle sign fix-up.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic              sign_a_q;
  logic              sign_b_q;
  logic [XLEN-1:0]   mag_a_q;
  logic [XLEN-1:0]   mag_b_q;
  logic [2*XLEN-1:0] prod_q;
  logic [XLEN:0]     rem_q;
  logic [XLEN-1:0]   quo_q;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        rd_out_q;
  logic              valid_q;

  logic              a_signed;
  logic              b_signed;
  logic              in_sign_a;
  logic              in_sign_b;
  logic [XLEN-1:0]   in_mag_a;
  logic [XLEN-1:0]   in_mag_b;
  logic [XLEN-1:0]   fast_res;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_d;
  logic [XLEN:0]     rem_shift;
  logic [XLEN:0]     div_trial;
  logic [XLEN:0]     rem_d;
  logic [XLEN-1:0]   quo_d;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_res;
  logic              unused_rem_top;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (bus.funct3)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      OP_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
    in_sign_a = a_signed & bus.op_a[XLEN-1];
    in_sign_b = b_signed & bus.op_b[XLEN-1];
    in_mag_a  = in_sign_a ? -bus.op_a : bus.op_a;
    in_mag_b  = in_sign_b ? -bus.op_b : bus.op_b;
    if (bus.op_b == '0) fast_res = bus.funct3[1] ? bus.op_a : DIV_ZERO_Q;
    else                fast_res = bus.funct3[1] ? '0 : INT_MIN;
  end

  always_comb begin
    // Multiply: add multiplicand into the high half when the low bit is set, then shift right.
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? mag_a_q : '0)};
    prod_d    = {mul_sum, prod_q[XLEN-1:1]};
    rem_shift = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    div_trial = rem_shift - {1'b0, mag_b_q};
    if (div_trial[XLEN]) begin
      rem_d = rem_shift;
      quo_d = {quo_q[XLEN-2:0], 1'b0};
    end else begin
      rem_d = div_trial;
      quo_d = {quo_q[XLEN-2:0], 1'b1};
    end
  end

  // Bit 32 only carries the borrow during a step; a stored remainder is always below the divisor.
  assign unused_rem_top = rem_q[XLEN];

  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? -prod_q : prod_q;
    quo_fix  = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
    rem_fix  = sign_a_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    case (op_q)
      OP_MUL:                      fix_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             fix_res = quo_fix;
      default:                     fix_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      rd_out_q <= '0;
      valid_q  <= 1'b0;
    end else if (bus.flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (bus.start) begin
            op_q     <= bus.funct3;
            rd_q     <= bus.rd_in;
            sign_a_q <= in_sign_a;
            sign_b_q <= in_sign_b;
            mag_a_q  <= in_mag_a;
            mag_b_q  <= in_mag_b;
            prod_q   <= {{XLEN{1'b0}}, in_mag_b};
            rem_q    <= '0;
            quo_q    <= in_mag_a;
            cnt_q    <= '0;
            if (fast_path(bus.funct3, bus.op_a, bus.op_b)) begin
              result_q <= fast_res;
              rd_out_q <= bus.rd_in;
              valid_q  <= 1'b1;
              state_q  <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (op_q[2]) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
          end else begin
            prod_q <= prod_d;
          end
          if (cnt_q == CNT_W'(XLEN - 1)) state_q <= FIX;
        end
        FIX: begin
          result_q <= fix_res;
          rd_out_q <= rd_q;
          valid_q  <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy         = (state_q != IDLE);
  // A flush arriving in DONE must still cancel the register-file write.
  assign bus.result_valid = valid_q & ~bus.flush;
  assign bus.result       = result_q;
  assign bus.rd_out       = rd_out_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Consumes the two register-file read operands (rs1/rs2 data) and the decoded funct3.
- Produces a 32-bit result plus destination index that drive the register-file write port (write data, rd, write enable).
- Stalls the single-cycle datapath through busy while it runs.

Parameters:
- XLEN, 32, operand/result width; only 32 supported.
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- start  input  1  request; sampled only in IDLE.
- flush  input  1  abort in-flight operation.
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  32  rs1 data from register file.
- op_b  input  32  rs2 data from register file.
- rd_in  input  5  destination register index.
- busy  output  1  high in any state except IDLE.
- result_valid  output  1  one-cycle pulse; used directly as register-file write_enable.
- result  output  32  write data to register file.
- rd_out  output  5  write index to register file.

Behaviour:
- Interface: one clock (clk); reset synchronous, active-high.
- Reset values: state IDLE, busy 0, result_valid 0, result 0, rd_out 0, counter 0, internal accumulators 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1, flush=0:
  - Latch funct3, rd_in, sign flags, operand magnitudes.
  - Magnitudes: signed ops take abs value; MULHSU treats op_b as unsigned.
  - Go to CALC with counter=0.
  - Fast path instead goes straight to DONE with result loaded.
- Fast path (div/rem only):
  - op_b==0: DIV/DIVU result 0xFFFFFFFF; REM/REMU result op_a.
  - DIV/REM with op_a=0x80000000, op_b=0xFFFFFFFF: DIV 0x80000000, REM 0.
- CALC, 32 iterations (one per edge), counter increments, CALC->FIX when counter==31.
  - Multiply: shift-add on 64-bit product register.
  - Divide: restoring; remainder shift-subtract, quotient bit set when subtraction is non-negative.
- FIX, one cycle: sign correction.
  - Product negated when sign_a^sign_b (signed ops only).
  - Quotient negated when sign_a^sign_b.
  - Remainder takes sign_a.
  - Select result: MUL low 32; MULH/MULHSU/MULHU high 32; DIV/DIVU quotient; REM/REMU remainder.
  - Register result, go to DONE.
- DONE: result_valid=1, rd_out driven, busy=1; next edge -> IDLE.
- result and rd_out hold their last value after the pulse.
- Latency:
  - Normal op: result_valid is high in the cycle after the 34th rising edge, counting the start-sampling edge as edge 1.
  - Fast path: valid in the cycle after edge 1.
  - Back-to-back: next start accepted the cycle after DONE, so throughput is 1 op per 35 cycles.
- start while not IDLE: ignored, no queueing.
- flush in any state: next state IDLE, result_valid 0 that cycle; flush in DONE suppresses the pulse.
- start and flush in the same cycle: flush wins, request dropped.
- reset mid-operation: identical to reset values; no write issued.
- Operands are captured at start, so later op_a/op_b changes have no effect.
- Width rules: product register 64 bits; remainder register 33 bits to hold the subtraction borrow.

Decomposition:
- Package muldiv_pkg holds:
  - funct3 opcode constants (OP_MUL..OP_REMU).
  - state encoding (IDLE/CALC/FIX/DONE, 2 bits).
  - XLEN default.
  - DIV_ZERO_Q=0xFFFFFFFF and INT_MIN=0x80000000 constants.
- No sub-module required.
- Single module with one shared iteration counter and separate mul/div datapath registers.

Test Plan:
- MUL 7 x -3 (0x00000007, 0xFFFFFFFD), rd=5 -> result 0xFFFFFFEB, rd_out 5, result_valid single pulse 34 edges after start, busy high throughout.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 0x12345678/0 -> 0xFFFFFFFF and REM -> 0x12345678, each valid after 1 edge; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
- start asserted again in CALC cycle 10 with different operands -> ignored, original result delivered; flush in CALC cycle 20 -> busy drops next cycle, no result_valid pulse.
- reset asserted in cycle 15 of CALC -> all outputs 0 next cycle; new start afterwards completes normally with correct result.
